// File: rtl/if_prefetch.sv
// ---------------------------------------------------------------------------
// if_prefetch -- instruction fetch prefetch queue with a Wishbone classic
// read master.
//
// Fetches sequential instruction words over Wishbone into a DEPTH-entry
// queue and presents the head entry to decode. A redirect (branch/jump or
// exception) flushes the queue and restarts fetching at the new target.
//
// Handshakes:
//   Decode side: the head entry is transferred on a cycle where valid_o and
//   ready_i are both 1. valid_o never depends on ready_i, and the head
//   fields hold steady until that transfer.
//   Bus side: at most one request is open. wbm_cyc_o/wbm_stb_o rise
//   together and stay high, with wbm_addr_o stable, until wbm_ack_i or
//   wbm_err_i ends it.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   br_j_addr_i               branch/jump target
//   exception_addr_i          trap vector
//   sel_addr_i[1:0]           redirect request: [1] exception, [0] branch
//   ready_i                   decode pops the head entry
//   valid_o                   head entry present
//   instruction_o, pc_o       head instruction and its PC
//   access_fault_o            head entry was fetched with a bus error
//   wbm_*                     Wishbone classic read master
//   fsm_state                 current bus FSM state (debug)
//
// Build option: define IF_PREFETCH_FAULT_TAG_EN to keep a fault bit per
// entry. Without it, error responses enter the queue as a NOP.
// ---------------------------------------------------------------------------
module if_prefetch #(
  parameter logic [31:0] RESET_ADDR = 32'h8000_0000,
  parameter int          DEPTH      = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] br_j_addr_i,
  input  logic [31:0] exception_addr_i,
  input  logic [1:0]  sel_addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic        access_fault_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [31:0] wbm_addr_o,
  output logic [1:0]  fsm_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [31:0]   pc, pc_next;        // address of the current or next live fetch
  logic [31:0]   addr;               // address driven on the bus
  logic [CW-1:0] count, count_next;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          redirect, resp, push, pop, issue;
  logic [31:0]   redirect_addr;
  logic [31:0]   push_instr;

  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_pc    [DEPTH];

`ifdef IF_PREFETCH_FAULT_TAG_EN
  logic          push_fault;
  logic          mem_fault [DEPTH];
`endif

  always_comb begin
    redirect      = |sel_addr_i;
    redirect_addr = sel_addr_i[1] ? exception_addr_i : br_j_addr_i;
    resp          = wbm_ack_i | wbm_err_i;
    pop           = (count != '0) && ready_i && !redirect;
    // Only a live FETCH response enters the queue; its slot was reserved
    // when the request was issued, so the queue cannot overflow.
    push          = (state == FETCH) && resp && !redirect;

    count_next = count;
    if (redirect)          count_next = '0;
    else if (push && !pop) count_next = count + CW'(1);
    else if (pop && !push) count_next = count - CW'(1);

    state_next = state;
    pc_next    = pc;
    case (state)
      IDLE: begin
        if (redirect)             pc_next    = redirect_addr;
        else if (count < DEPTH_C) state_next = FETCH;
      end
      FETCH: begin
        if (redirect) begin
          pc_next = redirect_addr;
          // A response landing with the redirect closes the request, so the
          // new target can go out straight away; otherwise drain the old one.
          state_next = resp ? FETCH : DRAIN;
        end else if (resp) begin
          pc_next    = pc + 32'd4;
          state_next = (count_next < DEPTH_C) ? FETCH : IDLE;
        end
      end
      DRAIN: begin
        if (redirect) pc_next    = redirect_addr;
        if (resp)     state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase

    // A new request starts whenever FETCH is entered or re-entered after a
    // response; wbm_addr_o only changes at those points.
    issue = (state_next == FETCH) && ((state != FETCH) || resp);

`ifdef IF_PREFETCH_FAULT_TAG_EN
    push_instr = wbm_dat_i;
    push_fault = wbm_err_i;
`else
    push_instr = wbm_err_i ? NOP : wbm_dat_i;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      pc     <= RESET_ADDR & 32'hFFFF_FFFC;
      addr   <= RESET_ADDR & 32'hFFFF_FFFC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next & 32'hFFFF_FFFC;
      if (issue) addr <= pc_next & 32'hFFFF_FFFC;
      count <= count_next;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Queue storage needs no reset: count gates every read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_instr[wr_ptr] <= push_instr;
      mem_pc[wr_ptr]    <= addr;
`ifdef IF_PREFETCH_FAULT_TAG_EN
      mem_fault[wr_ptr] <= push_fault;
`endif
    end
  end

  assign valid_o       = (count != '0);
  assign instruction_o = mem_instr[rd_ptr];
  assign pc_o          = mem_pc[rd_ptr];
`ifdef IF_PREFETCH_FAULT_TAG_EN
  assign access_fault_o = valid_o && mem_fault[rd_ptr];
`else
  assign access_fault_o = 1'b0;
`endif
  assign wbm_cyc_o  = (state != IDLE);
  assign wbm_stb_o  = (state != IDLE);
  assign wbm_addr_o = addr;
  assign fsm_state  = state;

endmodule

// File: tb/tb_if_prefetch.sv
// ---------------------------------------------------------------------------
// tb_if_prefetch -- self-checking bench for if_prefetch (DEPTH = 4).
// A behavioural Wishbone slave returns slave_data(addr). The expected entry
// for every accepted response goes into exp_q, and the queue head is
// compared against it each cycle. The fetch address is predicted
// independently of the DUT.
// ---------------------------------------------------------------------------
module tb_if_prefetch;

  localparam logic [31:0] RST_ADDR = 32'h8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] br_j_addr_i = '0;
  logic [31:0] exception_addr_i = '0;
  logic [1:0]  sel_addr_i = '0;
  logic        ready_i = 1'b0;
  logic        valid_o;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;
  logic        access_fault_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i = 1'b0;
  logic        wbm_err_i = 1'b0;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic [31:0] wbm_addr_o;
  logic [1:0]  fsm_state;

  if_prefetch #(.RESET_ADDR(RST_ADDR), .DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .br_j_addr_i(br_j_addr_i), .exception_addr_i(exception_addr_i),
    .sel_addr_i(sel_addr_i), .ready_i(ready_i),
    .valid_o(valid_o), .instruction_o(instruction_o), .pc_o(pc_o),
    .access_fault_o(access_fault_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_addr_o(wbm_addr_o),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [64:0] exp_q[$];       // {fault, pc, instruction}
  logic [31:0] exp_addr;       // address of the current/next live fetch
  bit          req_new;        // next request seen on the bus is unchecked
  bit          drain;          // open request will be discarded
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ a[15:0]};
  endfunction

  function automatic logic [64:0] exp_entry(input logic [31:0] a, input bit err);
`ifdef IF_PREFETCH_FAULT_TAG_EN
    return {err, a, slave_data(a)};
`else
    return {1'b0, a, (err ? NOP : slave_data(a))};
`endif
  endfunction

  // ---------------- driver tasks ----------------
  // Called at posedge+1: checks the registered outputs, drives this cycle's
  // inputs, updates the model, then advances one clock.
  task automatic cycle(input bit ack_en, input bit err_en, input bit rdy,
                       input logic [1:0] sel, input logic [31:0] br, input logic [31:0] exc);
    bit resp;
    check("valid", 65'(valid_o), 65'(exp_q.size() != 0));
    if (valid_o && exp_q.size() != 0)
      check("head", {access_fault_o, pc_o, instruction_o}, exp_q[0]);
    if (wbm_cyc_o && req_new) begin
      check("addr", 65'(wbm_addr_o), 65'(exp_addr));
      req_new = 1'b0;
    end
    resp             = wbm_cyc_o && (ack_en || err_en);
    ready_i          = rdy;
    sel_addr_i       = sel;
    br_j_addr_i      = br;
    exception_addr_i = exc;
    wbm_ack_i        = resp && !err_en;
    wbm_err_i        = resp && err_en;
    wbm_dat_i        = wbm_cyc_o ? slave_data(wbm_addr_o) : 32'h0;

    if (exp_q.size() != 0 && rdy && sel == 2'b00) void'(exp_q.pop_front());
    if (resp) begin
      if (!drain && sel == 2'b00) begin
        exp_q.push_back(exp_entry(exp_addr, err_en));
        exp_addr = exp_addr + 32'd4;
      end
      drain   = 1'b0;
      req_new = 1'b1;
    end
    if (sel != 2'b00) begin
      exp_q.delete();
      exp_addr = (sel[1] ? exc : br) & 32'hFFFF_FFFC;
      if (wbm_cyc_o && !resp) drain = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input int n, input bit ack_en, input bit rdy);
    for (int i = 0; i < n; i++) cycle(ack_en, 1'b0, rdy, 2'b00, 32'h0, 32'h0);
  endtask

  task automatic do_reset(input int n);
    rst_i = 1'b1; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
    sel_addr_i = 2'b00; ready_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    exp_q.delete();
    exp_addr = RST_ADDR; req_new = 1'b1; drain = 1'b0;
    check("rst_valid", 65'(valid_o), 65'(0));
    check("rst_cyc",   65'(wbm_cyc_o), 65'(0));
    check("rst_stb",   65'(wbm_stb_o), 65'(0));
    check("rst_fault", 65'(access_fault_o), 65'(0));
    check("rst_state", 65'(fsm_state), 65'(0));
    rst_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset release and streaming with ack every cycle.
    do_reset(3);
    cycle(1'b1, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    check("first_req_cyc",  65'(wbm_cyc_o), 65'(1));
    check("first_req_addr", 65'(wbm_addr_o), 65'(RST_ADDR));
    run(12, 1'b1, 1'b1);

    // Fill to full with ready low, then resume.
    do_reset(1);
    run(5, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("full_idle", 65'(wbm_cyc_o), 65'(0));
      cycle(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    end
    run(16, 1'b1, 1'b1);

    // Exception beats branch mid-request; stale ack dropped.
    do_reset(1);
    run(3, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 2'b11, 32'h8000_0200, 32'h8000_0100);
    check("redir_flush", 65'(valid_o), 65'(0));
    check("drain_cyc",   65'(wbm_cyc_o), 65'(1));
    cycle(1'b1, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    check("redir_cyc",  65'(wbm_cyc_o), 65'(1));
    check("redir_addr", 65'(wbm_addr_o), 65'(32'h8000_0100));

    // Second redirect during DRAIN moves the target (low bits ignored).
    cycle(1'b0, 1'b0, 1'b1, 2'b01, 32'h8000_0300, 32'h0);
    cycle(1'b0, 1'b0, 1'b1, 2'b01, 32'h8000_0383, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    check("redir2_addr", 65'(wbm_addr_o), 65'(32'h8000_0380));

    // Redirect coincident with ack.
    cycle(1'b1, 1'b0, 1'b1, 2'b01, 32'h8000_0040, 32'h0);
    check("coinc_cyc",   65'(wbm_cyc_o), 65'(1));
    check("coinc_addr",  65'(wbm_addr_o), 65'(32'h8000_0040));
    check("coinc_valid", 65'(valid_o), 65'(0));
    run(8, 1'b1, 1'b1);

    // Bus error at 8000_0008.
    do_reset(1);
    cycle(1'b1, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 2'b00, 32'h0, 32'h0);
    check("err_valid", 65'(valid_o), 65'(1));
    check("err_pc",    65'(pc_o), 65'(32'h8000_0008));
`ifdef IF_PREFETCH_FAULT_TAG_EN
    check("err_fault", 65'(access_fault_o), 65'(1));
    check("err_instr", 65'(instruction_o), 65'(slave_data(32'h8000_0008)));
`else
    check("err_fault", 65'(access_fault_o), 65'(0));
    check("err_instr", 65'(instruction_o), 65'(NOP));
`endif
    run(6, 1'b1, 1'b1);

    // Reset during FETCH with three entries queued; late ack ignored.
    do_reset(1);
    run(4, 1'b1, 1'b0);
    check("pre_rst_valid", 65'(valid_o), 65'(1));
    check("pre_rst_cyc",   65'(wbm_cyc_o), 65'(1));
    do_reset(1);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    wbm_ack_i = 1'b0;
    check("late_ack_valid", 65'(valid_o), 65'(0));
    check("late_ack_cyc",   65'(wbm_cyc_o), 65'(1));
    run(12, 1'b1, 1'b1);

    // Random traffic: stalls, errors, back-pressure and redirects.
    for (int i = 0; i < 400; i++) begin
      bit          a, e, r;
      logic [1:0]  s;
      logic [31:0] b, x;
      a = ($urandom_range(0, 3) != 0);
      e = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 2) != 0);
      s = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      b = 32'h8000_1000 | 32'($urandom_range(0, 1023));
      x = 32'h8000_2000 | 32'($urandom_range(0, 1023));
      cycle(a, e, r, s, b, x);
    end
    run(12, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 SHALL have parameter RESET_ADDR, default 32'h8000_0000: first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4: queue entries; legal values 2, 4, 8, 16.
REQ-003 SHALL have port clk_i  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port br_j_addr_i  in  32  branch/jump target.
REQ-006 SHALL have port exception_addr_i  in  32  trap vector.
REQ-007 SHALL have port sel_addr_i  in  2  redirect request: bit1 exception, bit0 branch/jump.
REQ-008 SHALL have port ready_i  in  1  decode accepts head entry (pop).
REQ-009 SHALL have port valid_o  out  1  head entry present.
REQ-010 SHALL have port instruction_o  out  32  head instruction.
REQ-011 SHALL have port pc_o  out  32  head PC.
REQ-012 SHALL have port access_fault_o  out  1  head entry fetched with bus error.
REQ-013 SHALL have ports wbm_dat_i in 32, wbm_ack_i in 1, wbm_err_i in 1, wbm_cyc_o out 1, wbm_stb_o out 1, wbm_addr_o out 32: Wishbone classic read master.

Function
REQ-014 SHALL hold at most one outstanding bus request; wbm_cyc_o and wbm_stb_o are asserted together and held with wbm_addr_o stable until ack or err.
REQ-015 SHALL use states IDLE (no request), FETCH (request active), DRAIN (request active, response to be discarded).
REQ-016 SHALL go IDLE->FETCH when count plus outstanding < DEPTH and no redirect this cycle; FETCH->IDLE/FETCH on ack|err per space; FETCH->DRAIN on redirect without same-cycle ack|err; DRAIN->FETCH on ack|err.
REQ-017 SHALL push {fault, PC, instruction} on ack|err in FETCH; fetch PC then advances by 4.
REQ-018 SHALL present the head registered: valid_o rises the cycle after the accepting ack; no combinational path bus->outputs.
REQ-019 SHALL pop when valid_o and ready_i; simultaneous push and pop keeps count unchanged.
REQ-020 SHALL keep count in 0..DEPTH; pointers are log2(DEPTH) bits wrapping modulo DEPTH.
REQ-021 SHALL never push when full (space reserved at issue); valid_o=0 when empty regardless of ready_i.
REQ-022 SHALL, on any sel_addr_i bit set, flush queue (valid_o=0 next cycle), load fetch PC with exception_addr_i if bit1 else br_j_addr_i (exception wins when both set).
REQ-023 SHALL discard ack|err coinciding with a redirect; next request issues the following cycle at the new address.
REQ-024 SHALL discard the DRAIN response; a second redirect during DRAIN only updates the target address.
REQ-025 SHALL drive wbm_addr_o[1:0] = 2'b00 (fetch PC word-aligned; bits 1:0 of redirect targets ignored).

Reset
REQ-026 SHALL on rst_i=1: state IDLE, count 0, pointers 0, fetch PC RESET_ADDR, wbm_cyc_o=wbm_stb_o=0, valid_o=0, access_fault_o=0 at next edge.
REQ-027 SHALL abandon an in-flight request on reset; ack/err arriving after reset is ignored.
REQ-028 SHALL issue the first request at RESET_ADDR the cycle after rst_i deasserts.

Configuration
REQ-029 SHALL use macro IF_PREFETCH_FAULT_TAG_EN.
REQ-030 SHALL, with the macro defined, store a fault bit per entry; wbm_err_i entries give access_fault_o=1 with instruction_o = captured wbm_dat_i.
REQ-031 SHALL, without the macro, store no fault bit, tie access_fault_o to 0, and push 32'h0000_0013 (NOP) for a wbm_err_i response.

Verification
REQ-032 SHALL cover: reset release, ack every cycle, ready_i=1 -> requests at 8000_0000, 8000_0004, ...; valid_o one cycle after each ack, pc_o in order.
REQ-033 SHALL cover: DEPTH=4, ready_i=0 -> exactly 4 pushes, then wbm_cyc_o stays 0; ready_i=1 resumes fetch same-order pc_o.
REQ-034 SHALL cover: sel_addr_i=2'b11, exception_addr_i=8000_0100, br_j_addr_i=8000_0200 mid-request -> queue empties, stale ack dropped, next wbm_addr_o=8000_0100.
REQ-035 SHALL cover: redirect coincident with ack -> no push, next request next cycle at br_j_addr_i=8000_0040.
REQ-036 SHALL cover: wbm_err_i at 8000_0008 -> macro on: access_fault_o=1, pc_o=8000_0008; macro off: instruction_o=0000_0013, access_fault_o=0.
REQ-037 SHALL cover: rst_i during FETCH with queue 3 deep -> valid_o=0, wbm_cyc_o=0 next cycle; late ack ignored; refetch from 8000_0000.
